// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the response status codes, the responder FSM state encoding, the
// word width, and a helper that derives store byte lanes from an address offset.
package dmem_pkg;

  localparam int WORD_BITS  = 64;
  localparam int WORD_BYTES = 8;

  localparam logic [1:0] STAT_AOK = 2'h0;
  localparam logic [1:0] STAT_HLT = 2'h1;
  localparam logic [1:0] STAT_ADR = 2'h2;
  localparam logic [1:0] STAT_INS = 2'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    SPLIT = 2'd3
  } state_t;

  // Byte lanes of the lower word touched by a store starting at byte offset off.
  // The upper word of a split store uses the complement.
  function automatic logic [WORD_BYTES-1:0] lo_byte_mask(input logic [2:0] off);
    logic [WORD_BYTES-1:0] m;
    m = 8'hFF << off;
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM behind the data-memory responder.
// Each cycle with en=1 either writes the byte lanes selected by we, or (we=0)
// registers the addressed word onto rdata. rdata holds between reads.
// Ports:
//   clock  - rising-edge clock
//   en     - port enable
//   we     - per-byte write enable (8 lanes, lane 0 = least significant byte)
//   addr   - word index
//   wdata  - write word
//   rdata  - registered read word
// Array contents are zero-filled at power-up.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int    DEPTH_BITS = 9,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [DEPTH_BITS-1:0] addr,
  input  logic [WORD_BITS-1:0]  wdata,
  output logic [WORD_BITS-1:0]  rdata
);

  logic [WORD_BITS-1:0] mem [0:(1<<DEPTH_BITS)-1];

  // Power-up contents: all zero
  initial begin
    for (int i = 0; i < (1 << DEPTH_BITS); i++) begin
      mem[i] = 64'h0;
    end
  end

  // Byte-lane writes and registered read share the single port
  always_ff @(posedge clock) begin
    if (en) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (we[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      if (we == 8'h00) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: the memory end of the pipeline's M-stage data port.
// One request at a time over valid/ready; the response (rdata + 2-bit status)
// appears LATENCY cycles after acceptance and is held until resp_ready.
// Stores commit on the acceptance edge; loads sample the array on the edge
// entering RESP. Bad addresses return STAT_ADR with rdata=0 and no write.
// Ports:
//   clock, reset          - clock, asynchronous active-high reset
//   req_valid / req_ready - request handshake
//   req_write             - 1 = store, 0 = load
//   req_addr, req_wdata   - byte address, little-endian store data
//   resp_valid/resp_ready - response handshake
//   resp_rdata, resp_stat - load data (0 for stores/errors), STAT_AOK/STAT_ADR
// Optional feature macro: DMEM_MISALIGN_SPLIT_EN -- in-range misaligned
// accesses are split into two word accesses through an extra SPLIT state.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    ADDR_BITS = 12,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WORD_BITS-1:0] req_addr,
  input  logic [WORD_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_BITS-1:0] resp_rdata,
  output logic [1:0]           resp_stat
);

  localparam int IDX_BITS = ADDR_BITS - 3;

  state_t                state;
  state_t                next_state;
  logic [3:0]            cnt;
  logic [IDX_BITS-1:0]   idx_q;
  logic [1:0]            stat_q;
  logic                  load_ok_q;
  logic                  ready_q;
  logic                  valid_q;

  logic                  req_oor;
  logic                  req_mis;
  logic                  req_adr;

  logic                  arr_en;
  logic [WORD_BYTES-1:0] arr_we;
  logic [IDX_BITS-1:0]   arr_addr;
  logic [WORD_BITS-1:0]  arr_wdata;
  logic [WORD_BITS-1:0]  arr_rdata;

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic                  req_split;
  logic                  split_q;
  logic                  wr_q;
  logic [2:0]            off_q;
  logic [WORD_BITS-1:0]  wdata_q;
  logic [WORD_BITS-1:0]  lo_word_q;
  logic [127:0]          req_lanes;
  logic [127:0]          held_lanes;
  logic [127:0]          load_lanes;
`endif

  // Classify the incoming address; only meaningful on the acceptance cycle
  always_comb begin
    req_oor = |req_addr[WORD_BITS-1:ADDR_BITS];
    req_mis = |req_addr[2:0];
`ifdef DMEM_MISALIGN_SPLIT_EN
    // An in-range misaligned access crosses the top only from the last word
    req_adr   = req_oor | (req_mis & (&req_addr[ADDR_BITS-1:3]));
    req_split = req_mis & ~req_adr;
`else
    req_adr   = req_oor | req_mis;
`endif
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  // Byte-lane alignment of store data and reassembly of split load data
  always_comb begin
    req_lanes  = {64'h0, req_wdata} << {req_addr[2:0], 3'b000};
    held_lanes = {64'h0, wdata_q} << {off_q, 3'b000};
    load_lanes = {arr_rdata, lo_word_q} >> {off_q, 3'b000};
  end
`endif

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY > 1) begin
            next_state = WAIT;
`ifdef DMEM_MISALIGN_SPLIT_EN
          end else if (req_split) begin
            next_state = SPLIT;
`endif
          end else begin
            next_state = RESP;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
          if (split_q) begin
            next_state = SPLIT;
          end else begin
            next_state = RESP;
          end
`else
          next_state = RESP;
`endif
        end else begin
          next_state = WAIT;
        end
      end
      RESP: begin
        if (resp_ready) begin
          next_state = IDLE;
        end else begin
          next_state = RESP;
        end
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      SPLIT: next_state = RESP;
`endif
      default: next_state = IDLE;
    endcase
  end

  // FSM output logic: drive the array port for the current state
  always_comb begin
    arr_en    = 1'b0;
    arr_we    = 8'h00;
    arr_addr  = idx_q;
    arr_wdata = 64'h0;
    case (state)
      IDLE: begin
        arr_addr = req_addr[ADDR_BITS-1:3];
        if (req_valid && !req_adr) begin
          if (req_write) begin
            // Store commits on the acceptance edge
            arr_en = 1'b1;
`ifdef DMEM_MISALIGN_SPLIT_EN
            arr_we    = lo_byte_mask(req_addr[2:0]);
            arr_wdata = req_lanes[63:0];
`else
            arr_we    = 8'hFF;
            arr_wdata = req_wdata;
`endif
          end else if (LATENCY == 1) begin
            // Acceptance edge is also the edge leaving for RESP/SPLIT
            arr_en = 1'b1;
          end else begin
            arr_en = 1'b0;
          end
        end else begin
          arr_en = 1'b0;
        end
      end
      WAIT: begin
        // Read on the final WAIT edge so data lands as the response opens
        if ((cnt == 4'd1) && load_ok_q) begin
          arr_en = 1'b1;
        end else begin
          arr_en = 1'b0;
        end
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      SPLIT: begin
        // Second word: finish the store or fetch the upper half of the load
        arr_addr = idx_q + {{(IDX_BITS-1){1'b0}}, 1'b1};
        arr_en   = 1'b1;
        if (wr_q) begin
          arr_we    = ~lo_byte_mask(off_q);
          arr_wdata = held_lanes[127:64];
        end else begin
          arr_we = 8'h00;
        end
      end
`endif
      default: arr_en = 1'b0;
    endcase
  end

  // Request capture at acceptance and latency countdown
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      stat_q    <= STAT_AOK;
      load_ok_q <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            idx_q     <= req_addr[ADDR_BITS-1:3];
            stat_q    <= req_adr ? STAT_ADR : STAT_AOK;
            load_ok_q <= ~req_write & ~req_adr;
            cnt       <= 4'(LATENCY - 1);
          end
        end
        WAIT: cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  // Split-access context and lower-word holding register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      split_q   <= 1'b0;
      wr_q      <= 1'b0;
      off_q     <= 3'd0;
      wdata_q   <= 64'h0;
      lo_word_q <= 64'h0;
    end else begin
      if ((state == IDLE) && req_valid) begin
        split_q <= req_split;
        wr_q    <= req_write;
        off_q   <= req_addr[2:0];
        wdata_q <= req_wdata;
      end
      if (state == SPLIT) begin
        lo_word_q <= arr_rdata;
      end
    end
  end
`endif

  // Handshake output registers follow the state being entered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      ready_q <= (next_state == IDLE);
      valid_q <= (next_state == RESP);
    end
  end

  // Load data is the RAM's output register, zeroed for stores and errors
  always_comb begin
    if (load_ok_q) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
      if (split_q) begin
        resp_rdata = load_lanes[63:0];
      end else begin
        resp_rdata = arr_rdata;
      end
`else
      resp_rdata = arr_rdata;
`endif
    end else begin
      resp_rdata = 64'h0;
    end
  end

  assign req_ready  = ready_q & ~reset;
  assign resp_valid = valid_q;
  assign resp_stat  = stat_q;

  dmem_array #(
    .DEPTH_BITS(IDX_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clock(clock),
    .en   (arr_en),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 uses LATENCY=2, instance 1
// uses LATENCY=1. Expected responses come from a byte-level memory model.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int AB = 12;
  localparam int TO = 60;
  localparam logic [63:0] LIM = 64'h1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [63:0] req_addr   [2];
  logic [63:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [63:0] resp_rdata [2];
  logic [1:0]  resp_stat  [2];

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  stat;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mdl [int];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_BITS(AB), .LATENCY(2)) u_dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_stat(resp_stat[0])
  );

  dmem_responder #(.ADDR_BITS(AB), .LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_stat(resp_stat[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int mkey(input int d, input logic [63:0] ba);
    return d * 65536 + int'(ba[AB-1:3]);
  endfunction

  function automatic logic [7:0] mdl_rd(input int d, input logic [63:0] ba);
    logic [63:0] w;
    int k;
    k = mkey(d, ba);
    w = mdl.exists(k) ? mdl[k] : 64'h0;
    return w[8*ba[2:0] +: 8];
  endfunction

  task automatic mdl_wr(input int d, input logic [63:0] ba, input logic [7:0] v);
    logic [63:0] w;
    int k;
    k = mkey(d, ba);
    w = mdl.exists(k) ? mdl[k] : 64'h0;
    w[8*ba[2:0] +: 8] = v;
    mdl[k] = w;
  endtask

  // Expected response of one access; applies store effects to the model
  task automatic predict(input int d, input bit wr, input logic [63:0] a, input logic [63:0] wd,
                         output logic [63:0] er, output logic [1:0] es, output int el);
    bit adr;
    bit mis;
    int base;
    base = (d == 0) ? 2 : 1;
    mis  = (a[2:0] != 3'd0);
    adr  = (a >= LIM);
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (!adr && mis && ((a + 64'd7) >= LIM)) adr = 1'b1;
    el = base + ((mis && !adr) ? 1 : 0);
`else
    if (mis) adr = 1'b1;
    el = base;
`endif
    er = 64'h0;
    es = adr ? 2'h2 : 2'h0;
    if (!adr) begin
      for (int b = 0; b < 8; b++) begin
        if (wr) mdl_wr(d, a + 64'(b), wd[8*b +: 8]);
        else    er[8*b +: 8] = mdl_rd(d, a + 64'(b));
      end
    end
  endtask

  // One request/response; hold>0 back-pressures the response for hold cycles
  task automatic xact(input string tag, input int d, input bit wr, input logic [63:0] a,
                      input logic [63:0] wd, input int hold);
    exp_t e;
    int   cyc;
    @(negedge clock);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    resp_ready[d] = (hold == 0);
    cyc = 0;
    while (req_ready[d] !== 1'b1 && cyc < TO) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_accept_timeout"}, 64'(cyc >= TO), 64'h0);
    predict(d, wr, a, wd, e.rdata, e.stat, e.lat);
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (hold > 0) begin
      // A competing store that must be ignored while busy
      req_write[d] = 1'b1;
      req_addr[d]  = 64'h48;
      req_wdata[d] = 64'hDEADBEEF_DEADBEEF;
    end else begin
      req_valid[d] = 1'b0;
    end
    cyc = 1;
    @(negedge clock);
    while (resp_valid[d] !== 1'b1 && cyc < TO) begin
      @(negedge clock);
      cyc++;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, 64'(cyc), 64'(e.lat));
    check({tag, "_rdata"}, resp_rdata[d], e.rdata);
    check({tag, "_stat"}, 64'(resp_stat[d]), 64'(e.stat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({tag, "_hold_valid"}, 64'(resp_valid[d]), 64'h1);
      check({tag, "_hold_rdata"}, resp_rdata[d], e.rdata);
      check({tag, "_hold_stat"}, 64'(resp_stat[d]), 64'(e.stat));
      check({tag, "_hold_ready"}, 64'(req_ready[d]), 64'h0);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] er;
    logic [1:0]  es;
    int          el;
    logic [63:0] addrs[$];
    logic [63:0] a;

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d]  = 1'b0;
      req_write[d]  = 1'b0;
      req_addr[d]   = 64'h0;
      req_wdata[d]  = 64'h0;
      resp_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clock);
    check("rst_ready_low", 64'(req_ready[0]), 64'h0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", 64'(req_ready[0]), 64'h1);
    check("rst_valid", 64'(resp_valid[0]), 64'h0);
    check("rst_rdata", resp_rdata[0], 64'h0);
    check("rst_stat", 64'(resp_stat[0]), 64'h0);

    // Aligned store then load
    xact("st100", 0, 1'b1, 64'h100, 64'h11223344_55667788, 0);
    xact("ld100", 0, 1'b0, 64'h100, 64'h0, 0);

    // Out-of-range store must not alias into the array
    xact("stff8", 0, 1'b1, 64'hFF8, 64'hA5A50FF8_5A5AF00F, 0);
    xact("st1000", 0, 1'b1, 64'h1000, 64'hBAD0BAD0_BAD0BAD0, 0);
    xact("ldff8", 0, 1'b0, 64'hFF8, 64'h0, 0);
    xact("ld000", 0, 1'b0, 64'h0, 64'h0, 0);
    xact("ldhigh", 0, 1'b0, 64'h8000_0000_0000_0100, 64'h0, 0);

    // Back-pressure on a load while a competing store is presented
    xact("st40", 0, 1'b1, 64'h40, 64'h40404040_40404040, 0);
    xact("st48", 0, 1'b1, 64'h48, 64'h48484848_48484848, 0);
    xact("ld40bp", 0, 1'b0, 64'h40, 64'h0, 5);
    repeat (3) begin
      @(negedge clock);
      check("no_phantom_valid", 64'(resp_valid[0]), 64'h0);
    end
    xact("ld48", 0, 1'b0, 64'h48, 64'h0, 0);

    // Reset one cycle after a store is accepted
    @(negedge clock);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 64'h200;
    req_wdata[0] = 64'hCAFEF00D_12345678;
    check("rstmid_ready", 64'(req_ready[0]), 64'h1);
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    predict(0, 1'b1, 64'h200, 64'hCAFEF00D_12345678, er, es, el);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rstmid_valid", 64'(resp_valid[0]), 64'h0);
    check("rstmid_ready_after", 64'(req_ready[0]), 64'h1);
    xact("ld200", 0, 1'b0, 64'h200, 64'h0, 0);

    // Misaligned accesses
    xact("st100b", 0, 1'b1, 64'h100, 64'h07060504_03020100, 0);
    xact("st108", 0, 1'b1, 64'h108, 64'h0F0E0D0C_0B0A0908, 0);
    xact("ld103", 0, 1'b0, 64'h103, 64'h0, 0);
    xact("st10d", 0, 1'b1, 64'h10D, 64'hEEDDCCBB_AA998877, 0);
    xact("ld108", 0, 1'b0, 64'h108, 64'h0, 0);
    xact("ld110", 0, 1'b0, 64'h110, 64'h0, 0);
    xact("stffc", 0, 1'b1, 64'hFFC, 64'h12121212_34343434, 0);
    xact("ldff8b", 0, 1'b0, 64'hFF8, 64'h0, 0);

    // LATENCY=1 instance: random aligned stores and loads
    for (int i = 0; i < 20; i++) begin
      if ((i % 2) == 0 || addrs.size() == 0) begin
        a = {52'h0, 9'($urandom_range(0, 511)), 3'b000};
        addrs.push_back(a);
        xact("l1_st", 1, 1'b1, a, {$urandom, $urandom}, 0);
      end else begin
        a = addrs[$urandom_range(0, addrs.size() - 1)];
        xact("l1_ld", 1, 1'b0, a, 64'h0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
